// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// | Module   : irq_arbiter_pkg                                               |
// | Purpose  : Shared definitions for the interrupt arbiter: FSM state       |
// |            encodings, register address map and INSV field positions.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// ============================================================================
package irq_arbiter_pkg;

  // Handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // Register address map on the device bus
  localparam logic [1:0] C_ADDR_MASK = 2'b00;
  localparam logic [1:0] C_ADDR_PEND = 2'b01;
  localparam logic [1:0] C_ADDR_INSV = 2'b10;
  localparam logic [1:0] C_ADDR_EDGE = 2'b11;

  // Bus data width and INSV valid flag position
  localparam int C_DATA_W         = 32;
  localparam int C_INSV_VALID_BIT = 31;

endpackage : irq_arbiter_pkg
`default_nettype wire

// File: rtl/irq_arbiter_prio_enc.sv
`default_nettype none
// ============================================================================
// | Module   : irq_arbiter_prio_enc                                          |
// | Purpose  : Combinational fixed-priority encoder; lowest set index wins.  |
// | Ports    : req [N_IRQ-1:0] in  - request vector                          |
// |            any             out - at least one request set                |
// |            id  [ID_W-1:0]  out - index of winning request (0 if none)    |
// | Revision : 1.0  initial release                                          |
// ============================================================================
module irq_arbiter_prio_enc #(
  parameter int N_IRQ = 6,
  parameter int ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  // Scan from the top down so the last hit, the lowest index, is kept.
  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule : irq_arbiter_prio_enc
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// | Module   : irq_arbiter                                                   |
// | Purpose  : Interrupt controller between bus devices and the CPU.         |
// |            Latches IRQ lines (level or edge), masks them, picks the      |
// |            lowest-index pending line and runs a request/ack/EOI          |
// |            handshake with the CPU.                                       |
// | Ports    : clk, reset (async, active-high)                               |
// |            irq_in  [N_IRQ-1:0] raw device IRQ lines                      |
// |            addr, IC_Wr, DataIn, DataOut : register bus                   |
// |              00 MASK (rw), 01 PEND (r/W1C), 10 INSV (r), 11 EDGE (rw)    |
// |            cpu_irq, irq_id : request to CPU                              |
// |            cpu_ack, cpu_eoi : CPU handshake pulses                       |
// | Revision : 1.0  initial release                                          |
// ============================================================================
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_IRQ = 6,
  parameter int ID_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic [1:0]          addr,
  input  logic                IC_Wr,
  input  logic [C_DATA_W-1:0] DataIn,
  output logic [C_DATA_W-1:0] DataOut,
  output logic                cpu_irq,
  output logic [ID_W-1:0]     irq_id,
  input  logic                cpu_ack,
  input  logic                cpu_eoi
);

  irq_state_t         r_state;
  irq_state_t         w_state_next;
  logic [ID_W-1:0]    r_irq_id;
  logic [ID_W-1:0]    w_id_next;

  logic [N_IRQ-1:0]   r_mask;
  logic [N_IRQ-1:0]   r_pend;
  logic [N_IRQ-1:0]   r_edge;
  logic [N_IRQ-1:0]   r_prev;

  logic [N_IRQ-1:0]   w_pend_next;
  logic [N_IRQ-1:0]   w_rise;
  logic [N_IRQ-1:0]   w_w1c;
  logic [N_IRQ-1:0]   w_ack_clr;
  logic [N_IRQ-1:0]   w_id_onehot;
  logic [N_IRQ-1:0]   w_req;
  logic               w_req_sel;
  logic               w_any;
  logic [ID_W-1:0]    w_win_id;
  logic               w_ack_take;
  logic               w_wr_mask;
  logic               w_wr_edge;
  logic               w_wr_pend;

  // Upper data bits have no register behind them.
  logic               w_unused_datain;
  assign w_unused_datain = ^DataIn[C_DATA_W-1:N_IRQ];

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_wr_mask = IC_Wr && (addr == C_ADDR_MASK);
  assign w_wr_edge = IC_Wr && (addr == C_ADDR_EDGE);
  assign w_wr_pend = IC_Wr && (addr == C_ADDR_PEND);

  // --------------------------------------------------------------------------
  // Pending logic
  // --------------------------------------------------------------------------
  assign w_rise      = irq_in & ~r_prev;
  assign w_w1c       = w_wr_pend ? DataIn[N_IRQ-1:0] : '0;
  assign w_id_onehot = N_IRQ'(1'b1) << r_irq_id;
  assign w_ack_take  = (r_state == ST_ASSERT) && cpu_ack;
  assign w_ack_clr   = w_ack_take ? w_id_onehot : '0;

  // Edge lines: a new rising edge beats any clear in the same cycle.
  // Level lines simply track the input; clears do not touch them.
  assign w_pend_next = (r_edge & (w_rise | (r_pend & ~(w_w1c | w_ack_clr))))
                     | (~r_edge & irq_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_pend <= '0;
      r_edge <= '0;
      r_prev <= '0;
    end else begin
      if (w_wr_mask) r_mask <= DataIn[N_IRQ-1:0];
      if (w_wr_edge) r_edge <= DataIn[N_IRQ-1:0];
      r_prev <= irq_in;
      r_pend <= w_pend_next;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign w_req     = r_pend & r_mask;
  // Whether the line currently presented to the CPU is still requesting.
  assign w_req_sel = |(w_req & w_id_onehot);

  irq_arbiter_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req (w_req),
    .any (w_any),
    .id  (w_win_id)
  );

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_next;
      r_irq_id <= w_id_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_id_next    = r_irq_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_id_next    = w_win_id;
          w_state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // An ack arriving together with a drop still commits the interrupt.
        if (cpu_ack) begin
          w_state_next = ST_SERVICE;
        end else if (!w_req_sel) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (cpu_eoi) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Decoded straight from the async-reset state so reset drops it at once.
  assign cpu_irq = (r_state == ST_ASSERT);
  assign irq_id  = r_irq_id;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    DataOut = '0;
    case (addr)
      C_ADDR_MASK: DataOut[N_IRQ-1:0] = r_mask;
      C_ADDR_PEND: DataOut[N_IRQ-1:0] = r_pend;
      C_ADDR_INSV: begin
        DataOut[C_INSV_VALID_BIT] = (r_state == ST_SERVICE);
        DataOut[ID_W-1:0]         = r_irq_id;
      end
      C_ADDR_EDGE: DataOut[N_IRQ-1:0] = r_edge;
      default:     DataOut = '0;
    endcase
  end

endmodule : irq_arbiter
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// | Module   : tb_irq_arbiter                                                |
// | Purpose  : Self-checking bench for irq_arbiter. Expected request ids are |
// |            queued when IRQ stimulus is driven and popped when cpu_irq    |
// |            is due; register reads are compared against constants.       |
// | Revision : 1.0  initial release                                          |
// ============================================================================
module tb_irq_arbiter;
  import irq_arbiter_pkg::*;

  localparam int N_IRQ = 6;
  localparam int ID_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_IRQ-1:0]  irq_in;
  logic [1:0]        addr;
  logic              IC_Wr;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              cpu_irq;
  logic [ID_W-1:0]   irq_id;
  logic              cpu_ack;
  logic              cpu_eoi;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ID_W-1:0] sb_q[$];
  logic [31:0]     rd;

  irq_arbiter #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .addr    (addr),
    .IC_Wr   (IC_Wr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .cpu_irq (cpu_irq),
    .irq_id  (irq_id),
    .cpu_ack (cpu_ack),
    .cpu_eoi (cpu_eoi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; DataIn = d; IC_Wr = 1'b1;
    tick();
    IC_Wr = 1'b0; DataIn = '0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = DataOut;
  endtask

  task automatic pulse_ack();
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    cpu_eoi = 1'b1; tick(); cpu_eoi = 1'b0;
  endtask

  // Pop the next expected request and compare it with what the DUT presents.
  task automatic pop_req(input string tag);
    logic [ID_W-1:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_irq"}, 32'(cpu_irq), 32'd1);
      check({tag, "_id"}, 32'(irq_id), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; addr = '0; IC_Wr = 1'b0;
    DataIn = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_irq", 32'(cpu_irq), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    for (int a = 0; a < 4; a++) begin
      reg_rd(2'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, 32'd0);
    end

    // 1: level timer line, two-clock latency, ack, eoi with line still high
    reg_wr(C_ADDR_MASK, 32'h01);
    irq_in = 6'b000001; sb_q.push_back(3'd0);
    tick();
    check("t1_lat", 32'(cpu_irq), 32'd0);
    tick();
    pop_req("t1_req");
    pulse_ack();
    check("t1_ack_irq", 32'(cpu_irq), 32'd0);
    reg_rd(C_ADDR_INSV, rd);
    check("t1_insv", rd, 32'h8000_0000);
    sb_q.push_back(3'd0);
    pulse_eoi();
    check("t1_eoi_idle", 32'(cpu_irq), 32'd0);
    tick();
    pop_req("t1_rereq");
    irq_in = '0;
    tick(); tick();
    check("t1_drop", 32'(cpu_irq), 32'd0);

    // 2: edge mode, simultaneous pulses on lines 3 and 1
    reg_wr(C_ADDR_EDGE, 32'h3F);
    reg_wr(C_ADDR_MASK, 32'h3F);
    irq_in = 6'b001010; sb_q.push_back(3'd1); sb_q.push_back(3'd3);
    tick();
    irq_in = '0;
    tick();
    pop_req("t2_first");
    reg_rd(C_ADDR_PEND, rd);
    check("t2_pend_both", rd, 32'h0A);
    pulse_ack();
    pulse_eoi();
    tick();
    pop_req("t2_second");
    pulse_ack();
    reg_rd(C_ADDR_PEND, rd);
    check("t2_pend_clr", rd, 32'h00);
    pulse_eoi();
    check("t2_idle", 32'(cpu_irq), 32'd0);

    // 3: mask removed while presenting id 2
    irq_in = 6'b000100; sb_q.push_back(3'd2);
    tick();
    irq_in = '0;
    tick();
    pop_req("t3_req");
    reg_wr(C_ADDR_MASK, 32'h00);
    check("t3_hold", 32'(cpu_irq), 32'd1);
    tick();
    check("t3_drop", 32'(cpu_irq), 32'd0);
    reg_rd(C_ADDR_PEND, rd);
    check("t3_pend_kept", rd, 32'h04);
    reg_wr(C_ADDR_PEND, 32'h04);
    reg_rd(C_ADDR_PEND, rd);
    check("t3_w1c", rd, 32'h00);

    // 4: higher priority arrival during service of id 4 does not preempt
    reg_wr(C_ADDR_MASK, 32'h3F);
    irq_in = 6'b010000; sb_q.push_back(3'd4);
    tick();
    irq_in = '0;
    tick();
    pop_req("t4_req");
    pulse_ack();
    irq_in = 6'b000001;
    tick();
    irq_in = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_no_preempt%0d", k), 32'(cpu_irq), 32'd0);
    end
    reg_rd(C_ADDR_INSV, rd);
    check("t4_insv", rd, 32'h8000_0004);
    sb_q.push_back(3'd0);
    pulse_eoi();
    tick();
    pop_req("t4_after_eoi");
    pulse_ack();
    pulse_eoi();

    // 5: W1C and new rising edge on line 5 in the same cycle: set wins
    reg_wr(C_ADDR_MASK, 32'h00);
    irq_in = 6'b100000;
    tick();
    irq_in = '0;
    tick();
    reg_rd(C_ADDR_PEND, rd);
    check("t5_pend", rd, 32'h20);
    irq_in = 6'b100000;
    reg_wr(C_ADDR_PEND, 32'h20);
    reg_rd(C_ADDR_PEND, rd);
    check("t5_set_wins", rd, 32'h20);
    irq_in = '0;
    tick();
    reg_wr(C_ADDR_PEND, 32'h20);
    reg_rd(C_ADDR_PEND, rd);
    check("t5_w1c", rd, 32'h00);

    // 6: asynchronous reset during ASSERT, then spurious ack/eoi in IDLE
    reg_wr(C_ADDR_MASK, 32'h01);
    irq_in = 6'b000001; sb_q.push_back(3'd0);
    tick(); tick();
    pop_req("t6_req");
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_irq", 32'(cpu_irq), 32'd0);
    for (int a = 0; a < 4; a++) begin
      reg_rd(2'(a), rd);
      check($sformatf("t6_async_reg%0d", a), rd, 32'd0);
    end
    irq_in = '0;
    tick();
    reset = 1'b0;
    tick();
    cpu_ack = 1'b1; cpu_eoi = 1'b1;
    tick();
    cpu_ack = 1'b0; cpu_eoi = 1'b0;
    check("t6_spur_irq", 32'(cpu_irq), 32'd0);
    reg_rd(C_ADDR_INSV, rd);
    check("t6_spur_insv", rd, 32'd0);
    tick();
    check("t6_spur_irq2", 32'(cpu_irq), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_irq_arbiter
`default_nettype wire
